// File: rtl/constants_pkg.sv
// Shared constants for the pipeline: architectural width, MEM-stage FSM
// states and the load/store width encodings carried in func3.
package constants_pkg;

  localparam int unsigned ARCH_LEN = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2
  } mem_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/structure_pkg.sv
// Decoded-instruction record passed between pipeline registers.
package structure_pkg;

  import constants_pkg::*;

  typedef struct packed {
    logic                valid;
    logic [ARCH_LEN-1:0] pc;
    logic [4:0]          rd;
    logic                is_l;
    logic                is_s;
    logic [2:0]          func3;
    logic [ARCH_LEN-1:0] src_data_1;
    logic [ARCH_LEN-1:0] src_data_2;
    logic [ARCH_LEN-1:0] dst_reg_data;
    logic                reg_data_ready;
  } inst_decoded_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the byte/half at the byte offset out of the
// returned memory word and sign- or zero-extends it per func3.
module mem_load_align
  import constants_pkg::*;
(
  input  logic [ARCH_LEN-1:0] rdata,
  input  logic [1:0]          off,
  input  logic [2:0]          func3,
  output logic [ARCH_LEN-1:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select and extension
  always_comb begin
    case (off)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = off[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      LSU_B:   result = {{(ARCH_LEN-8){w_byte[7]}}, w_byte};
      LSU_H:   result = {{(ARCH_LEN-16){w_half[15]}}, w_half};
      LSU_BU:  result = {{(ARCH_LEN-8){1'b0}}, w_byte};
      LSU_HU:  result = {{(ARCH_LEN-16){1'b0}}, w_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: req/gnt/rvalid data-memory handshake for loads and
// stores, load alignment/extension, registered result toward writeback.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned access trap and
// misalign_out port). Without it, halfwords use off[1] and words ignore off.
module memory_stage
  import constants_pkg::*;
  import structure_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  inst_decoded_t       inst_mem_in,
  output inst_decoded_t       inst_wb_out,
  output logic                stall_mem_out,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ARCH_LEN-1:0] dmem_addr,
  output logic [ARCH_LEN-1:0] dmem_wdata,
  output logic [3:0]          dmem_be,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [ARCH_LEN-1:0] dmem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                misalign_out
`endif
);

  mem_state_t          r_state;
  mem_state_t          w_state_next;
  logic [1:0]          w_off;
  logic [1:0]          w_eff_off;
  logic [1:0]          w_size;
  logic                w_is_store;
  logic                w_is_load;
  logic                w_mem_op;
  logic                w_misalign;
  logic                w_misalign_hit;
  logic                w_issue;
  logic                w_req;
  logic                w_stall;
  logic                w_complete;
  logic [3:0]          w_be;
  logic [ARCH_LEN-1:0] w_wdata;
  logic [ARCH_LEN-1:0] w_load_data;
  inst_decoded_t       w_wb_next;

  assign w_off      = inst_mem_in.dst_reg_data[1:0];
  assign w_size     = inst_mem_in.func3[1:0];
  assign w_is_store = inst_mem_in.is_s;
  assign w_is_load  = inst_mem_in.is_l & ~inst_mem_in.is_s;
  assign w_mem_op   = inst_mem_in.valid & (inst_mem_in.is_l | inst_mem_in.is_s);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = ((w_size == 2'b01) & w_off[0]) |
                      ((w_size == 2'b10) & (w_off != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue        = w_mem_op & ~w_misalign;
  assign w_misalign_hit = (r_state == IDLE) & w_mem_op & w_misalign;

  // Effective byte offset: halfwords see only off[1], words are always lane 0
  always_comb begin
    case (w_size)
      2'b00:   w_eff_off = w_off;
      2'b01:   w_eff_off = {w_off[1], 1'b0};
      default: w_eff_off = '0;
    endcase
  end

  // Byte enables for loads and stores, lane-replicated store data
  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    if (w_issue) begin
      case (w_size)
        2'b00:   w_be = 4'b0001 << w_eff_off;
        2'b01:   w_be = 4'b0011 << w_eff_off;
        default: w_be = 4'b1111;
      endcase
      if (w_is_store) begin
        case (w_size)
          2'b00:   w_wdata = {4{inst_mem_in.src_data_2[7:0]}};
          2'b01:   w_wdata = {2{inst_mem_in.src_data_2[15:0]}};
          default: w_wdata = inst_mem_in.src_data_2;
        endcase
      end
    end
  end

  mem_load_align u_load_align (
    .rdata  (dmem_rdata),
    .off    (w_eff_off),
    .func3  (inst_mem_in.func3),
    .result (w_load_data)
  );

  // Handshake decode: request, stall, completion and next state
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_req = 1'b1;
          if (dmem_gnt && w_is_store) begin
            w_complete = 1'b1;
          end else if (dmem_gnt) begin
            w_stall      = 1'b1;
            w_state_next = WAIT_RESP;
          end else begin
            w_stall      = 1'b1;
            w_state_next = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (dmem_gnt && w_is_store) begin
          w_stall      = 1'b0;
          w_complete   = 1'b1;
          w_state_next = IDLE;
        end else if (dmem_gnt) begin
          w_state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        w_stall = 1'b1;
        if (dmem_rvalid) begin
          w_stall      = 1'b0;
          w_complete   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Writeback payload: pass-through with load data merged on completion
  always_comb begin
    w_wb_next = inst_mem_in;
    if (w_complete && w_is_load) begin
      w_wb_next.dst_reg_data   = w_load_data;
      w_wb_next.reg_data_ready = 1'b1;
    end
    if (w_complete && w_is_store) begin
      w_wb_next.reg_data_ready = 1'b0;
    end
  end

  assign dmem_req      = w_req & ~rst;
  assign stall_mem_out = w_stall & ~rst;
  assign dmem_we       = w_issue & w_is_store & ~rst;
  assign dmem_addr     = {inst_mem_in.dst_reg_data[ARCH_LEN-1:2], 2'b00};
  assign dmem_be       = w_be;
  assign dmem_wdata    = w_wdata;

  // FSM state and writeback register; stalls and traps emit a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      inst_wb_out <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_stall || w_misalign_hit) begin
        inst_wb_out.valid <= 1'b0;
      end else begin
        inst_wb_out <= w_wb_next;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;

  // One-cycle trap pulse aligned with the writeback register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign_hit;
    end
  end

  assign misalign_out = r_misalign;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: transaction-level reference model
// with randomized memory latencies, plus directed literal scenarios.
module tb_memory_stage;

  import constants_pkg::*;
  import structure_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  inst_decoded_t inst_mem_in;
  inst_decoded_t inst_wb_out;
  logic          stall_mem_out;
  logic          dmem_req;
  logic          dmem_we;
  logic [31:0]   dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_be;
  logic          dmem_gnt;
  logic          dmem_rvalid;
  logic [31:0]   dmem_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic          misalign_out;
`endif

  always #5 clk = ~clk;

  memory_stage dut (
    .clk           (clk),
    .rst           (rst),
    .inst_mem_in   (inst_mem_in),
    .inst_wb_out   (inst_wb_out),
    .stall_mem_out (stall_mem_out),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_out  (misalign_out)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expectations consumed by the per-cycle compare process
  bit            chk_en = 1'b0;
  logic          exp_req, exp_stall, exp_we, exp_wb_valid, exp_mis;
  logic [31:0]   exp_addr, exp_wdata;
  logic [3:0]    exp_be;
  inst_decoded_t exp_wb;

  // Observations from the most recent run_inst
  int            obs_stall_cnt, obs_req_cnt;
  logic [3:0]    obs_be0;
  logic [31:0]   obs_addr0, obs_wdata0;
  logic          obs_we0;

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a[1:0];
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    int unsigned sh;
    logic [31:0] v;
    case (f3[1:0])
      2'b00:   sh = 8 * int'(a[1:0]);
      2'b01:   sh = a[1] ? 16 : 0;
      default: sh = 0;
    endcase
    v = w >> sh;
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
      3'b001: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
      3'b100: v = v & 32'hFF;
      3'b101: v = v & 32'hFFFF;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
  endfunction

  function automatic inst_decoded_t mk(input logic v, input logic l, input logic s,
                                       input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] d2);
    inst_decoded_t t;
    t.valid          = v;
    t.pc             = $urandom;
    t.rd             = 5'($urandom);
    t.is_l           = l;
    t.is_s           = s;
    t.func3          = f3;
    t.src_data_1     = $urandom;
    t.src_data_2     = d2;
    t.dst_reg_data   = a;
    t.reg_data_ready = 1'($urandom);
    return t;
  endfunction

  // Present one instruction for its whole stay in the stage. gdly = cycles
  // before gnt, rdly = extra cycles between gnt and rvalid for loads.
  task automatic run_inst(input inst_decoded_t in, input int gdly, input int rdly,
                          input logic [31:0] rword);
    logic mem, mis, iss, ld;
    int last;
    inst_decoded_t res;
    mem = in.valid && (in.is_l || in.is_s);
`ifdef MEM_MISALIGN_TRAP_EN
    mis = mem && m_misaligned(in.func3, in.dst_reg_data);
`else
    mis = 1'b0;
`endif
    iss  = mem && !mis;
    ld   = in.is_l && !in.is_s;
    last = !iss ? 0 : (ld ? gdly + 1 + rdly : gdly);
    res  = in;
    if (iss && ld) begin
      res.dst_reg_data   = m_load(in.func3, in.dst_reg_data, rword);
      res.reg_data_ready = 1'b1;
    end
    if (iss && in.is_s) res.reg_data_ready = 1'b0;
    obs_stall_cnt = 0;
    obs_req_cnt   = 0;
    for (int c = 0; c <= last; c++) begin
      inst_mem_in = in;
      dmem_gnt    = iss && (c == gdly);
      if (iss && ld && c == last) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rword;
      end else begin
        dmem_rvalid = (!iss || c <= gdly) ? ($urandom_range(0, 3) == 0) : 1'b0;
        dmem_rdata  = $urandom;
      end
      exp_req   = iss && (c <= gdly);
      exp_stall = iss && (c < last);
      exp_we    = in.is_s;
      exp_addr  = {in.dst_reg_data[31:2], 2'b00};
      exp_be    = m_be(in.func3, in.dst_reg_data);
      exp_wdata = in.is_s ? m_wdata(in.func3, in.src_data_2) : 32'h0;
      @(negedge clk);
      if (stall_mem_out) obs_stall_cnt++;
      if (dmem_req) obs_req_cnt++;
      if (c == 0) begin
        obs_be0    = dmem_be;
        obs_addr0  = dmem_addr;
        obs_wdata0 = dmem_wdata;
        obs_we0    = dmem_we;
      end
      @(posedge clk);
      #1;
      exp_mis = 1'b0;
      if (c < last) begin
        exp_wb_valid = 1'b0;
      end else begin
        exp_wb_valid = in.valid && !mis;
        exp_wb       = res;
        exp_mis      = mis;
      end
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model expectations
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 256'(stall_mem_out), 256'(exp_stall));
      check("req", 256'(dmem_req), 256'(exp_req));
      if (exp_req) begin
        check("we", 256'(dmem_we), 256'(exp_we));
        check("addr", 256'(dmem_addr), 256'(exp_addr));
        check("be", 256'(dmem_be), 256'(exp_be));
        check("wdata", 256'(dmem_wdata), 256'(exp_wdata));
      end
      check("wb_valid", 256'(inst_wb_out.valid), 256'(exp_wb_valid));
      if (exp_wb_valid) check("wb", 256'(inst_wb_out), 256'(exp_wb));
`ifdef MEM_MISALIGN_TRAP_EN
      check("misalign", 256'(misalign_out), 256'(exp_mis));
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] lf3 [5];
  logic [2:0] sf3 [3];

  initial begin
    inst_decoded_t t;
    int kind;
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    sf3 = '{3'b000, 3'b001, 3'b010};

    // Reset with a live load on the input: outputs must stay quiet
    rst          = 1'b1;
    inst_mem_in  = mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    dmem_gnt     = 1'b1;
    dmem_rvalid  = 1'b1;
    dmem_rdata   = 32'h1234_5678;
    exp_req      = 1'b0;
    exp_stall    = 1'b0;
    exp_we       = 1'b0;
    exp_addr     = '0;
    exp_be       = '0;
    exp_wdata    = '0;
    exp_wb_valid = 1'b0;
    exp_wb       = '0;
    exp_mis      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_wb_zero", 256'(inst_wb_out), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LB 0x103, gnt cycle 0, rvalid cycle 2
    run_inst(mk(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0), 0, 1, 32'h80FF_1234);
    check("lb_stall_cycles", 256'(obs_stall_cnt), 256'(2));
    check("lb_be", 256'(obs_be0), 256'(4'b1000));
    check("lb_dst", 256'(inst_wb_out.dst_reg_data), 256'(32'hFFFF_FF80));
    check("lb_valid", 256'(inst_wb_out.valid), 256'(1));

    // SH 0x202 with same-cycle gnt
    run_inst(mk(1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD), 0, 0, 32'h0);
    check("sh_addr", 256'(obs_addr0), 256'(32'h200));
    check("sh_be", 256'(obs_be0), 256'(4'b1100));
    check("sh_wdata", 256'(obs_wdata0), 256'(32'hABCD_ABCD));
    check("sh_we", 256'(obs_we0), 256'(1));
    check("sh_stall_cycles", 256'(obs_stall_cnt), 256'(0));

    // LHU 0x2 with gnt delayed 3 cycles
    run_inst(mk(1'b1, 1'b1, 1'b0, 3'b101, 32'h2, 32'h0), 3, 0, 32'h8001_0000);
    check("lhu_req_cycles", 256'(obs_req_cnt), 256'(4));
    check("lhu_dst", 256'(inst_wb_out.dst_reg_data), 256'(32'h0000_8001));

    // Non-memory instruction passes through untouched
    run_inst(mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h5), 0, 0, 32'h0);
    check("add_req_cycles", 256'(obs_req_cnt), 256'(0));
    check("add_dst", 256'(inst_wb_out.dst_reg_data), 256'(32'h1234_5678));
    check("add_valid", 256'(inst_wb_out.valid), 256'(1));

    // Reset while waiting for the load response, stale rvalid afterwards
    inst_mem_in = mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b0;
    exp_req     = 1'b1;
    exp_stall   = 1'b1;
    exp_we      = 1'b0;
    exp_addr    = 32'h10;
    exp_be      = 4'b1111;
    exp_wdata   = 32'h0;
    @(posedge clk);
    #1;
    exp_wb_valid = 1'b0;
    rst       = 1'b1;
    dmem_gnt  = 1'b0;
    exp_req   = 1'b0;
    exp_stall = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_wb_zero", 256'(inst_wb_out), 256'(0));
    rst         = 1'b0;
    inst_mem_in = mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    check("rst_mid_wb_invalid", 256'(inst_wb_out.valid), 256'(0));
    run_inst(mk(1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D), 0, 0, 32'h0);
    check("post_rst_store_valid", 256'(inst_wb_out.valid), 256'(1));

    // Back-to-back stores with gnt every cycle
    for (int i = 0; i < 8; i++) begin
      run_inst(mk(1'b1, 1'b0, 1'b1, sf3[$urandom_range(0, 2)], $urandom & 32'hFFFF_FFFC,
                  $urandom), 0, 0, 32'h0);
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load traps without a request
    run_inst(mk(1'b1, 1'b1, 1'b0, 3'b010, 32'h1, 32'h0), 0, 0, 32'h0);
    check("mis_req_cycles", 256'(obs_req_cnt), 256'(0));
    check("mis_pulse", 256'(misalign_out), 256'(1));
    check("mis_wb_valid", 256'(inst_wb_out.valid), 256'(0));
    run_inst(mk(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0), 0, 0, 32'h0);
    check("mis_pulse_end", 256'(misalign_out), 256'(0));
`endif

    // Randomized mix of loads, stores, ALU ops and bubbles
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 8);
      if (kind <= 1) begin
        t = mk(1'b1, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom);
      end else if (kind == 2) begin
        t = mk(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom);
      end else if (kind <= 5) begin
        t = mk(1'b1, 1'b1, 1'b0, lf3[$urandom_range(0, 4)], $urandom, $urandom);
      end else begin
        t = mk(1'b1, 1'b0, 1'b1, sf3[$urandom_range(0, 2)], $urandom, $urandom);
      end
      run_inst(t, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    inst_mem_in = mk(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    exp_req     = 1'b0;
    exp_stall   = 1'b0;
    @(posedge clk);
    #1;
    exp_wb_valid = 1'b0;
    exp_mis      = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
